// File: rtl/mul_sequencer_if.sv
// Handshake/data bundle between the EX stage and the multiply sequencer.
// The EX stage (master) drives the ALU control, operands and flush; the
// sequencer (slave) returns stall, busy, the valid pulse and the product.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       ALUCtrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output ALUCtrl_i, src1_i, src2_i, flush_i,
        input  stall_o, busy_o, valid_o, result_o
    );

    modport slave (
        input  ALUCtrl_i, src1_i, src2_i, flush_i,
        output stall_o, busy_o, valid_o, result_o
    );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiply sequencer for the EX stage.
// A MUL code seen in IDLE captures both operands and runs exactly WIDTH
// add/shift iterations, stalling the pipeline meanwhile, then presents the
// low WIDTH bits of the product with a single-cycle valid pulse in DONE.
module mul_sequencer #(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] MUL_CODE = 4'b1011
) (
    input logic             clk_i,
    input logic             rst_i,
    mul_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2*WIDTH-1:0]  mcand;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  acc_sum;
    logic [WIDTH-1:0]    mplier;
    logic [WIDTH-1:0]    result_r;
    logic [CW-1:0]       cnt;
    logic                start;
    logic                last_iter;
    logic                stall;
    logic                busy;
    logic                valid;

    // Starting is only legal from IDLE, so a MUL still sitting in EX during
    // DONE cannot retrigger; reset is folded in so stall drops the moment
    // reset is asserted, even while a MUL is on the control lines.
    assign start     = rst_i && (state == IDLE) && (bus.ALUCtrl_i == MUL_CODE) && !bus.flush_i;
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign acc_sum   = mplier[0] ? (acc + mcand) : acc;

    // State register with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; flush overrides everything and returns to IDLE
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (bus.flush_i) begin
            state_next = IDLE;
            stall      = 1'b0;
            valid      = 1'b0;
        end
    end

    // Operand capture, shift-add iteration and result latch on the final iteration
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_r <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, bus.src1_i};
            mplier <= bus.src2_i;
            acc    <= '0;
            cnt    <= '0;
        end else if ((state == BUSY) && !bus.flush_i) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last_iter) begin
                result_r <= acc_sum[WIDTH-1:0];
            end
        end
    end

    assign bus.stall_o  = stall;
    assign bus.busy_o   = busy;
    assign bus.valid_o  = valid;
    assign bus.result_o = result_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed testbench for mul_sequencer: hand-computed products, stall/valid
// timing, back-to-back starts, flush abort, asynchronous reset and non-MUL codes.
module tb_mul_sequencer;
    localparam logic [3:0] MUL = 4'b1011;
    localparam logic [3:0] ADD = 4'b0010;

    logic        clk;
    logic        rst_n;
    int          vector_count;
    int          error_count;
    logic [31:0] last_result;

    mul_sequencer_if #(.WIDTH(32)) bus ();

    mul_sequencer #(.WIDTH(32), .MUL_CODE(4'b1011)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] b, input logic fl);
        bus.ALUCtrl_i = ctrl;
        bus.src1_i    = a;
        bus.src2_i    = b;
        bus.flush_i   = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
        end
    endtask

    // Runs one MUL starting in the current cycle (T0) and checks every cycle
    // through DONE (T33); returns positioned just after the edge into T34.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res);
        applyStimulus(MUL, a, b, 1'b0);
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            checkOutput("stall", {31'd0, bus.stall_o}, {31'd0, (k <= 32)});
            checkOutput("busy", {31'd0, bus.busy_o}, {31'd0, (k >= 1 && k <= 32)});
            checkOutput("valid", {31'd0, bus.valid_o}, {31'd0, (k == 33)});
            if (k == 32) checkOutput("hold", bus.result_o, last_result);
            if (k == 33) checkOutput("product", bus.result_o, exp_res);
            @(posedge clk);
            #1;
            if (k == 0) applyStimulus(MUL, ~a, b + 32'd3, 1'b0);
        end
        last_result = exp_res;
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        checkOutput({tag, "_stall"}, {31'd0, bus.stall_o}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence
    initial begin
        logic [3:0] codes [5];
        codes[0] = 4'b0000;
        codes[1] = 4'b0010;
        codes[2] = 4'b0110;
        codes[3] = 4'b0111;
        codes[4] = 4'b1100;
        vector_count = 0;
        error_count  = 0;
        last_result  = 32'd0;
        rst_n        = 1'b0;
        applyStimulus(4'b0000, 32'd0, 32'd0, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        checkOutput("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("rst_result", bus.result_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_quiet("idle");

        $display("[TB] basic 6x7");
        run_mul(32'd6, 32'd7, 32'd42);
        applyStimulus(ADD, 32'd1, 32'd2, 1'b0);
        check_quiet("after_mul");

        $display("[TB] signed and truncation");
        run_mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
        applyStimulus(ADD, 32'd0, 32'd0, 1'b0);
        check_quiet("gap1");
        run_mul(32'h0001_0000, 32'h0001_0000, 32'd0);
        applyStimulus(ADD, 32'd0, 32'd0, 1'b0);
        check_quiet("gap2");

        $display("[TB] back-to-back 3x4 then 10x10");
        run_mul(32'd3, 32'd4, 32'd12);
        run_mul(32'd10, 32'd10, 32'd100);
        applyStimulus(ADD, 32'd0, 32'd0, 1'b0);
        check_quiet("gap3");

        $display("[TB] flush at T10 of 9x9");
        applyStimulus(MUL, 32'd9, 32'd9, 1'b0);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            checkOutput("fl_stall", {31'd0, bus.stall_o}, 32'd1);
            @(posedge clk);
            #1;
        end
        applyStimulus(MUL, 32'd9, 32'd9, 1'b1);
        @(negedge clk);
        checkOutput("fl_stall_t10", {31'd0, bus.stall_o}, 32'd0);
        checkOutput("fl_valid_t10", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("fl_busy_t10", {31'd0, bus.busy_o}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(4'b0000, 32'd0, 32'd0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checkOutput("fl_busy", {31'd0, bus.busy_o}, 32'd0);
            checkOutput("fl_valid", {31'd0, bus.valid_o}, 32'd0);
            checkOutput("fl_result", bus.result_o, last_result);
            @(posedge clk);
            #1;
        end

        $display("[TB] async reset mid-BUSY");
        applyStimulus(MUL, 32'd6, 32'd7, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_stall", {31'd0, bus.stall_o}, 32'd0);
        checkOutput("ar_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("ar_valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("ar_result", bus.result_o, 32'd0);
        applyStimulus(ADD, 32'd6, 32'd7, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_result = 32'd0;
        for (int k = 0; k < 3; k++) check_quiet("post_rst");
        @(negedge clk);
        checkOutput("post_rst_result", bus.result_o, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] non-MUL codes");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(codes[i], 32'd5, 32'd5, 1'b0);
            check_quiet("nonmul");
            check_quiet("nonmul");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, error_count);
        $finish;
    end

endmodule
